// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial ripple-borrow subtractor. Computes (a - b - bin) one bit per
//   clock, LSB first, with a single full-subtractor cell and a borrow flop.
//   A start/busy/done handshake loads the operands; diff and bout are
//   registered and only update on the edge that enters DONE.
//
// Ports
//   clk    in            system clock, rising edge
//   rst_n  in            asynchronous active-low reset
//   start  in            begin an operation (honoured only in IDLE)
//   a      in  [W-1:0]   minuend, captured on the accepting edge
//   b      in  [W-1:0]   subtrahend, captured on the accepting edge
//   bin    in            borrow-in, captured on the accepting edge
//   busy   out           high while bits are processed (SHIFT)
//   done   out           one-cycle pulse, diff/bout newly valid
//   diff   out [W-1:0]   (a - b - bin) mod 2^W
//   bout   out           1 iff a < b + bin
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last result
// SHIFT  | one bit processed per edge, LSB first
// DONE   | one-cycle result-valid pulse; start ignored

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Smallest counter that can hold WIDTH-1; exit happens at WIDTH-1 so it never wraps.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Full-subtractor cell on the current LSBs.
  logic a0, b0, d_bit, br_next;
  logic [WIDTH-1:0] d_shifted;

  always_comb begin
    a0        = a_sh_q[0];
    b0        = b_sh_q[0];
    d_bit     = a0 ^ b0 ^ br_q;
    br_next   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    d_shifted = {d_bit, d_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        d_sh_d = d_shifted;
        br_d   = br_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = d_shifted;
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
